// File: rtl/xprog_loader.sv
// Boot loader: turns a valid/ready byte stream into program RAM writes and holds the CPU in reset
// until a complete image is in place. Define XLOAD_CHKSUM_EN to expect and verify a trailing XOR checksum byte.
module xprog_loader #(
  parameter int INSTR_W     = 32,
  parameter int PROG_ADDR_W = 10,
  parameter int BYTE_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [BYTE_W-1:0]      byte_data,
  output logic                   byte_ready,
  output logic                   prog_we,
  output logic [PROG_ADDR_W-1:0] prog_addr,
  output logic [INSTR_W-1:0]     prog_data,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int BYTES = INSTR_W / BYTE_W;
  localparam int BC_W  = $clog2(BYTES) + 1;
  localparam logic [16:0] CAPACITY = 17'(2 ** PROG_ADDR_W);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, FLUSH, DONE, ERR} state_t;

  state_t                 state, state_d;
  logic [15:0]            len_q, len_d, len_new;
  logic [15:0]            word_cnt, word_d;
  logic [BC_W-1:0]        byte_cnt, byte_d;
  logic [BYTE_W-1:0]      chksum, sum_d;
  logic [PROG_ADDR_W-1:0] addr_d;
  logic [INSTR_W-1:0]     data_d;
  logic                   we_d;
  logic                   xfer;

  assign xfer = byte_valid & byte_ready;

  always_comb begin
    state_d = state;
    len_d   = len_q;
    len_new = {len_q[15:8], byte_data};
    word_d  = word_cnt;
    byte_d  = byte_cnt;
    sum_d   = chksum;
    data_d  = prog_data;
    addr_d  = prog_addr;
    we_d    = 1'b0;
    // Address moves on after each write pulse, except after the final word so it cannot wrap.
    if (prog_we && word_cnt != len_q)
      addr_d = prog_addr + 1'b1;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          len_d   = '0;
          word_d  = '0;
          byte_d  = '0;
          sum_d   = '0;
          addr_d  = '0;
          data_d  = '0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d   = {byte_data, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if ({1'b0, len_new} > CAPACITY)
            state_d = ERR;
          else if (len_new == 16'd0)
`ifdef XLOAD_CHKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          data_d = (prog_data << BYTE_W) | INSTR_W'(byte_data);
          sum_d  = chksum ^ byte_data;
          if (byte_cnt == BC_W'(BYTES - 1)) begin
            byte_d = '0;
            word_d = word_cnt + 16'd1;
            we_d   = 1'b1;
            if (word_d == len_q)
`ifdef XLOAD_CHKSUM_EN
              state_d = CHK;
`else
              state_d = FLUSH;
`endif
          end else begin
            byte_d = byte_cnt + 1'b1;
          end
        end
      end
`ifdef XLOAD_CHKSUM_EN
      CHK: begin
        if (xfer)
          state_d = (byte_data == chksum) ? DONE : ERR;
      end
`else
      FLUSH: state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      chksum     <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      byte_ready <= 1'b0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      len_q      <= len_d;
      word_cnt   <= word_d;
      byte_cnt   <= byte_d;
      chksum     <= sum_d;
      prog_we    <= we_d;
      prog_addr  <= addr_d;
      prog_data  <= data_d;
      byte_ready <= state_d inside {LEN_HI, LEN_LO, DATA, CHK};
      cpu_rst    <= (state_d != DONE);
      busy       <= state_d inside {LEN_HI, LEN_LO, DATA, CHK, FLUSH};
      done       <= (state_d == DONE);
      error      <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_xprog_loader.sv
// Directed self-checking bench for xprog_loader; follows the checksum build when XLOAD_CHKSUM_EN is defined.
module tb_xprog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int passes = 0;

  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  xprog_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Capture every RAM write in the middle of its cycle.
  always @(negedge clk) begin
    if (prog_we) begin
      wa.push_back(prog_addr);
      wd.push_back(prog_data);
    end
  end

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      byte_valid = 1'b0;
      wait_cycles(1);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      wait_cycles(1);
      n++;
    end
    if (n >= 50) check_output("ready_timeout", 64'd0, 64'd1);
    wait_cycles(1);
    byte_valid = 1'b0;
  endtask

  task automatic send_payload(input bit gap);
    logic [7:0] img [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) send_byte(img[i], gap);
  endtask

  task automatic check_two_writes(input string tag, input int base);
    check_output({tag, "_wcount"}, 64'(wa.size() - base), 64'd2);
    if (wa.size() - base >= 2) begin
      check_output({tag, "_addr0"}, 64'(wa[base]), 64'd0);
      check_output({tag, "_data0"}, 64'(wd[base]), 64'h11223344);
      check_output({tag, "_addr1"}, 64'(wa[base+1]), 64'd1);
      check_output({tag, "_data1"}, 64'(wd[base+1]), 64'h55667788);
    end
  endtask

  task automatic check_done(input string tag);
    check_output({tag, "_done"}, 64'(done), 64'd1);
    check_output({tag, "_error"}, 64'(error), 64'd0);
    check_output({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic load_good(input string tag, input bit gap);
    int base = wa.size();
    pulse_start();
    check_output({tag, "_busy_start"}, 64'(busy), 64'd1);
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_payload(gap);
`ifdef XLOAD_CHKSUM_EN
    send_byte(8'h88, gap);
`endif
    wait_cycles(2);
    check_two_writes(tag, base);
    check_done(tag);
  endtask

  initial begin
    int base;
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    wait_cycles(2);
    check_output("rst_ready", 64'(byte_ready), 64'd0);
    check_output("rst_we", 64'(prog_we), 64'd0);
    check_output("rst_addr", 64'(prog_addr), 64'd0);
    check_output("rst_data", 64'(prog_data), 64'd0);
    check_output("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_error", 64'(error), 64'd0);
    rst = 1'b1;
    wait_cycles(1);

    load_good("good", 1'b0);

`ifdef XLOAD_CHKSUM_EN
    base = wa.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_payload(1'b0);
    send_byte(8'h00, 1'b0);
    wait_cycles(2);
    check_two_writes("badsum", base);
    check_output("badsum_error", 64'(error), 64'd1);
    check_output("badsum_done", 64'(done), 64'd0);
    check_output("badsum_cpu_rst", 64'(cpu_rst), 64'd1);
    check_output("badsum_ready", 64'(byte_ready), 64'd0);
`endif

    // Oversize: N = 1025 exceeds 1024-word RAM.
    base = wa.size();
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    check_output("big_error", 64'(error), 64'd1);
    check_output("big_ready", 64'(byte_ready), 64'd0);
    check_output("big_cpu_rst", 64'(cpu_rst), 64'd1);
    wait_cycles(2);
    check_output("big_wcount", 64'(wa.size() - base), 64'd0);

    // Empty image.
    base = wa.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef XLOAD_CHKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    wait_cycles(1);
    check_done("empty");
    check_output("empty_wcount", 64'(wa.size() - base), 64'd0);

    load_good("gap", 1'b1);

    // Reset mid-load after five payload bytes.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    check_output("mid_addr_pre", 64'(prog_addr), 64'd1);
    rst = 1'b0;
    #1;
    check_output("mid_ready", 64'(byte_ready), 64'd0);
    check_output("mid_we", 64'(prog_we), 64'd0);
    check_output("mid_addr", 64'(prog_addr), 64'd0);
    check_output("mid_data", 64'(prog_data), 64'd0);
    check_output("mid_cpu_rst", 64'(cpu_rst), 64'd1);
    check_output("mid_busy", 64'(busy), 64'd0);
    check_output("mid_done", 64'(done), 64'd0);
    check_output("mid_error", 64'(error), 64'd0);
    wait_cycles(1);
    rst = 1'b1;
    wait_cycles(1);

    // Start while busy is ignored; start in DONE restarts.
    base = wa.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    pulse_start();
    check_output("restart_busy", 64'(busy), 64'd1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
`ifdef XLOAD_CHKSUM_EN
    send_byte(8'h88, 1'b0);
`endif
    wait_cycles(2);
    check_two_writes("ignore", base);
    check_done("ignore");
    pulse_start();
    check_output("redo_cpu_rst", 64'(cpu_rst), 64'd1);
    check_output("redo_busy", 64'(busy), 64'd1);
    check_output("redo_done", 64'(done), 64'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/xprog_loader.md
Name: xprog_loader

Overview:
Boot loader sitting directly upstream of the controller's program memory. It receives a byte stream (valid/ready), assembles it into instruction words and writes them into program RAM. It holds the controller in reset until a complete, checksum-verified image has been written. Its prog_* outputs drive the program RAM write port, and its cpu_rst output drives the controller's reset.

Parameters:
INSTR_W, 32, instruction word width; must be a multiple of 8
PROG_ADDR_W, 10, program RAM address width; capacity is 2**PROG_ADDR_W words
BYTE_W, 8, stream symbol width; fixed at 8, not to be overridden

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle pulse that begins a load
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
prog_we  output  1  program RAM write strobe, one cycle per word
prog_addr  output  PROG_ADDR_W  program RAM write address
prog_data  output  INSTR_W  program RAM write data
cpu_rst  output  1  active-high reset to the controller
busy  output  1  load in progress
done  output  1  last load completed successfully
error  output  1  last load failed

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-low.
- Reset values: state=IDLE, byte_ready=0, prog_we=0, prog_addr=0, prog_data=0, cpu_rst=1, busy=0, done=0, error=0. Internal word counter, byte counter and checksum are cleared.
- Handshake: a byte transfers on a rising edge where byte_valid & byte_ready. byte_ready is registered and is 1 only in LEN_HI, LEN_LO, DATA and CHK. byte_data is ignored when no transfer occurs. Gaps in byte_valid are allowed anywhere.
- Stream format:
  - 16-bit word count N, big-endian (LEN_HI byte, then LEN_LO byte).
  - N words of INSTR_W/8 bytes each, big-endian.
  - One checksum byte: XOR of all payload bytes. The length bytes are excluded from the checksum.
- IDLE:
  - start -> LEN_HI; busy=1, cpu_rst=1, done=0, error=0; checksum, address and counters cleared.
  - start is ignored in every state other than IDLE, DONE and ERR.
- LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
- LEN_LO: on transfer, latch N[7:0], then:
  - N > 2**PROG_ADDR_W -> ERR.
  - N = 0 -> CHK.
  - otherwise -> DATA.
- DATA:
  - Each accepted byte shifts into prog_data (left shift by 8, new byte in the LSBs) and is XORed into the checksum.
  - On acceptance of the INSTR_W/8-th byte of a word, prog_we=1 for exactly the next cycle, with prog_addr equal to the word index.
  - prog_addr increments on the cycle after the pulse. It never wraps, because N is bounded.
  - After the last word -> CHK.
- CHK: on transfer:
  - byte == checksum -> DONE.
  - otherwise -> ERR.
- DONE: busy=0, done=1, cpu_rst=0. cpu_rst falls on the edge after the checksum byte is accepted, which is always at least one cycle after the final prog_we pulse.
- ERR: busy=0, error=1, cpu_rst stays 1, byte_ready=0. Only start or reset leaves ERR.
- start in DONE or ERR behaves as in IDLE; cpu_rst is 1 on the following cycle.
- Reset asserted mid-load: immediate return to the reset values. The partially written RAM contents are left as-is.
- prog_we is never asserted outside DATA and the single cycle that follows it.

Optional Feature:
XLOAD_CHKSUM_EN
- Defined: the checksum byte and CHK state are present, as described above.
- Undefined:
  - No checksum byte is expected and the CHK state is absent.
  - After the final word's prog_we pulse, the loader goes to DONE on the next edge.
  - N = 0 goes from LEN_LO straight to DONE.
  - error is set only by the length check.

Test Plan:
1. Good load: start; bytes 00 02 11 22 33 44 55 66 77 88 88 -> prog_we pulses (addr 0, 0x11223344) and (addr 1, 0x55667788); then done=1, error=0, cpu_rst=0, busy=0.
2. Bad checksum: same bytes but final byte 00 -> two writes occur, then error=1, done=0, cpu_rst=1, byte_ready=0.
3. Oversize image: start; 04 01 (N=1025, PROG_ADDR_W=10) -> ERR on the next edge, no prog_we, byte_ready=0.
4. Empty image: start; 00 00 00 -> done=1, no prog_we. Without XLOAD_CHKSUM_EN: 00 00 alone -> done=1.
5. Backpressure and reset: bytes with byte_valid toggling every other cycle -> same writes as test 1. Then drive rst=0 after 5 payload bytes -> all outputs take their reset values immediately, cpu_rst=1.
6. start pulsed while busy -> ignored, load continues. start pulsed in DONE -> cpu_rst=1 and busy=1 the next cycle, done=0.
